// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the integer execute unit: ROB index width,
// data width, internal 6-bit opcode constants and the E2 result bundle.
package alu_exec_unit_pkg;

    localparam int ROB_INDEX_W = 4;
    localparam int DATA_W      = 32;

    localparam logic [5:0] OP_LUI   = 6'd1;
    localparam logic [5:0] OP_AUIPC = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_JALR  = 6'd4;
    localparam logic [5:0] OP_BEQ   = 6'd5;
    localparam logic [5:0] OP_BNE   = 6'd6;
    localparam logic [5:0] OP_BLT   = 6'd7;
    localparam logic [5:0] OP_BGE   = 6'd8;
    localparam logic [5:0] OP_BLTU  = 6'd9;
    localparam logic [5:0] OP_BGEU  = 6'd10;
    localparam logic [5:0] OP_LB    = 6'd11;
    localparam logic [5:0] OP_LH    = 6'd12;
    localparam logic [5:0] OP_LW    = 6'd13;
    localparam logic [5:0] OP_LBU   = 6'd14;
    localparam logic [5:0] OP_LHU   = 6'd15;
    localparam logic [5:0] OP_SB    = 6'd16;
    localparam logic [5:0] OP_SH    = 6'd17;
    localparam logic [5:0] OP_SW    = 6'd18;
    localparam logic [5:0] OP_ADDI  = 6'd19;
    localparam logic [5:0] OP_SLTI  = 6'd20;
    localparam logic [5:0] OP_SLTIU = 6'd21;
    localparam logic [5:0] OP_XORI  = 6'd22;
    localparam logic [5:0] OP_ORI   = 6'd23;
    localparam logic [5:0] OP_ANDI  = 6'd24;
    localparam logic [5:0] OP_SLLI  = 6'd25;
    localparam logic [5:0] OP_SRLI  = 6'd26;
    localparam logic [5:0] OP_SRAI  = 6'd27;
    localparam logic [5:0] OP_ADD   = 6'd28;
    localparam logic [5:0] OP_SUB   = 6'd29;
    localparam logic [5:0] OP_SLL   = 6'd30;
    localparam logic [5:0] OP_SLT   = 6'd31;
    localparam logic [5:0] OP_SLTU  = 6'd32;
    localparam logic [5:0] OP_XOR   = 6'd33;
    localparam logic [5:0] OP_SRL   = 6'd34;
    localparam logic [5:0] OP_SRA   = 6'd35;
    localparam logic [5:0] OP_OR    = 6'd36;
    localparam logic [5:0] OP_AND   = 6'd37;

    typedef struct packed {
        logic [DATA_W-1:0] val;
        logic              jump;
        logic [DATA_W-1:0] target;
    } alu_res_t;

endpackage

// File: rtl/alu_exec_unit_core.sv
// Combinational E2 datapath: result value, taken flag and next PC
// from one decoded instruction held in the E1 registers.
module alu_exec_core
    import alu_exec_unit_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [31:0] vj,
    input  logic [31:0] vk,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    output logic [31:0] val,
    output logic        jump,
    output logic [31:0] target
);

    logic signed [31:0] vj_s;
    logic signed [31:0] vk_s;
    logic signed [31:0] imm_s;
    logic        [31:0] pc_imm;
    logic        [31:0] pc_4;
    logic        [31:0] jalr_sum;

    assign vj_s     = vj;
    assign vk_s     = vk;
    assign imm_s    = imm;
    assign pc_imm   = pc + imm;
    assign pc_4     = pc + 32'd4;
    assign jalr_sum = vj + imm;

    // Decode and compute; anything unrecognised completes as a no-op result.
    always_comb begin
        logic is_br;
        logic taken;
        val    = '0;
        jump   = 1'b0;
        target = pc_4;
        is_br  = 1'b0;
        taken  = 1'b0;
        case (op)
            OP_LUI:   val = imm;
            OP_AUIPC: val = pc_imm;
            OP_JAL:   begin val = pc_4; jump = 1'b1; target = pc_imm; end
            OP_JALR:  begin val = pc_4; jump = 1'b1; target = {jalr_sum[31:1], 1'b0}; end
            OP_BEQ:   begin is_br = 1'b1; taken = (vj == vk);     end
            OP_BNE:   begin is_br = 1'b1; taken = (vj != vk);     end
            OP_BLT:   begin is_br = 1'b1; taken = (vj_s <  vk_s); end
            OP_BGE:   begin is_br = 1'b1; taken = (vj_s >= vk_s); end
            OP_BLTU:  begin is_br = 1'b1; taken = (vj <  vk);     end
            OP_BGEU:  begin is_br = 1'b1; taken = (vj >= vk);     end
            OP_ADDI:  val = vj + imm;
            OP_SLTI:  val = {31'd0, (vj_s < imm_s)};
            OP_SLTIU: val = {31'd0, (vj < imm)};
            OP_XORI:  val = vj ^ imm;
            OP_ORI:   val = vj | imm;
            OP_ANDI:  val = vj & imm;
            OP_SLLI:  val = vj << imm[4:0];
            OP_SRLI:  val = vj >> imm[4:0];
            OP_SRAI:  val = vj_s >>> imm[4:0];
            OP_ADD:   val = vj + vk;
            OP_SUB:   val = vj - vk;
            OP_SLL:   val = vj << vk[4:0];
            OP_SLT:   val = {31'd0, (vj_s < vk_s)};
            OP_SLTU:  val = {31'd0, (vj < vk)};
            OP_XOR:   val = vj ^ vk;
            OP_SRL:   val = vj >> vk[4:0];
            OP_SRA:   val = vj_s >>> vk[4:0];
            OP_OR:    val = vj | vk;
            OP_AND:   val = vj & vk;
            default:  val = '0;
        endcase
        if (is_br) begin
            jump = taken;
            if (taken) target = pc_imm;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Two-stage RV32I execute unit: E1 captures the issued instruction,
// E2 computes and registers the one-cycle broadcast pulse.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int ROB_W = ROB_INDEX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             roll,
    input  logic             in_valid,
    input  logic [5:0]       in_op,
    input  logic [31:0]      in_vj,
    input  logic [31:0]      in_vk,
    input  logic [ROB_W-1:0] in_rob_idx,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_pc,
    output logic             alu_flag,
    output logic [ROB_W-1:0] alu_rob_idx,
    output logic [31:0]      alu_val,
    output logic             alu_jump,
    output logic [31:0]      alu_target
);

    logic             flush;
    logic             vld_p1;
    logic [5:0]       op_p1;
    logic [31:0]      vj_p1;
    logic [31:0]      vk_p1;
    logic [31:0]      imm_p1;
    logic [31:0]      pc_p1;
    logic [ROB_W-1:0] rob_p1;
    alu_res_t         res_p1;

    // A misprediction flush behaves exactly like reset and overrides rdy.
    assign flush = rst | roll;

    // E1 valid: cleared by flush, frozen when rdy is low.
    always_ff @(posedge clk) begin
        if (flush)    vld_p1 <= 1'b0;
        else if (rdy) vld_p1 <= in_valid;
    end

    // E1 payload: captured only on an accepted issue; qualified by vld_p1.
    always_ff @(posedge clk) begin
        if (rdy && in_valid) begin
            op_p1  <= in_op;
            vj_p1  <= in_vj;
            vk_p1  <= in_vk;
            imm_p1 <= in_imm;
            pc_p1  <= in_pc;
            rob_p1 <= in_rob_idx;
        end
    end

    alu_exec_core u_core (
        .op     (op_p1),
        .vj     (vj_p1),
        .vk     (vk_p1),
        .imm    (imm_p1),
        .pc     (pc_p1),
        .val    (res_p1.val),
        .jump   (res_p1.jump),
        .target (res_p1.target)
    );

    // E2 broadcast registers: pulse follows vld_p1; payload holds between results.
    always_ff @(posedge clk) begin
        if (flush) begin
            alu_flag    <= 1'b0;
            alu_rob_idx <= '0;
            alu_val     <= '0;
            alu_jump    <= 1'b0;
            alu_target  <= '0;
        end else if (rdy) begin
            alu_flag <= vld_p1;
            if (vld_p1) begin
                alu_rob_idx <= rob_p1;
                alu_val     <= res_p1.val;
                alu_jump    <= res_p1.jump;
                alu_target  <= res_p1.target;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases with literal
// expectations, then randomized traffic against a behavioural model.
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, roll, in_valid;
    logic [5:0]  in_op;
    logic [31:0] in_vj, in_vk, in_imm, in_pc;
    logic [3:0]  in_rob_idx;
    logic        alu_flag, alu_jump;
    logic [3:0]  alu_rob_idx;
    logic [31:0] alu_val, alu_target;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    alu_exec_unit #(.ROB_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .roll(roll),
        .in_valid(in_valid), .in_op(in_op), .in_vj(in_vj), .in_vk(in_vk),
        .in_rob_idx(in_rob_idx), .in_imm(in_imm), .in_pc(in_pc),
        .alu_flag(alu_flag), .alu_rob_idx(alu_rob_idx), .alu_val(alu_val),
        .alu_jump(alu_jump), .alu_target(alu_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] vj, vk, imm, pc;
        logic [3:0]  rob;
    } ins_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural reference: what RV32I says each opcode produces.
    function automatic alu_res_t ref_exec(ins_t i);
        alu_res_t r;
        longint sj, sk, si;
        int sh_r, sh_i;
        sj = longint'($signed(i.vj));
        sk = longint'($signed(i.vk));
        si = longint'($signed(i.imm));
        sh_r = int'(i.vk % 32);
        sh_i = int'(i.imm % 32);
        r.val = 0; r.jump = 0; r.target = i.pc + 4;
        case (i.op)
            OP_LUI:   r.val = i.imm;
            OP_AUIPC: r.val = i.pc + i.imm;
            OP_JAL:   begin r.val = i.pc + 4; r.jump = 1; r.target = i.pc + i.imm; end
            OP_JALR:  begin r.val = i.pc + 4; r.jump = 1; r.target = (i.vj + i.imm) & 32'hFFFF_FFFE; end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                case (i.op)
                    OP_BEQ:  r.jump = (i.vj == i.vk);
                    OP_BNE:  r.jump = (i.vj != i.vk);
                    OP_BLT:  r.jump = (sj < sk);
                    OP_BGE:  r.jump = !(sj < sk);
                    OP_BLTU: r.jump = (longint'(i.vj) < longint'(i.vk));
                    default: r.jump = !(longint'(i.vj) < longint'(i.vk));
                endcase
                if (r.jump) r.target = i.pc + i.imm;
            end
            OP_ADDI:  r.val = 32'(longint'(i.vj) + longint'(i.imm));
            OP_SLTI:  r.val = (sj < si) ? 1 : 0;
            OP_SLTIU: r.val = (longint'(i.vj) < longint'(i.imm)) ? 1 : 0;
            OP_XORI:  r.val = i.vj ^ i.imm;
            OP_ORI:   r.val = i.vj | i.imm;
            OP_ANDI:  r.val = i.vj & i.imm;
            OP_SLLI:  r.val = 32'(longint'(i.vj) * (64'd1 << sh_i));
            OP_SRLI:  r.val = 32'(longint'(i.vj) / (64'd1 << sh_i));
            OP_SRAI:  r.val = (sj < 0) ? ~((~i.vj) >> sh_i) : (i.vj >> sh_i);
            OP_ADD:   r.val = 32'(longint'(i.vj) + longint'(i.vk));
            OP_SUB:   r.val = 32'(longint'(i.vj) - longint'(i.vk));
            OP_SLL:   r.val = 32'(longint'(i.vj) * (64'd1 << sh_r));
            OP_SLT:   r.val = (sj < sk) ? 1 : 0;
            OP_SLTU:  r.val = (longint'(i.vj) < longint'(i.vk)) ? 1 : 0;
            OP_XOR:   r.val = i.vj ^ i.vk;
            OP_SRL:   r.val = 32'(longint'(i.vj) / (64'd1 << sh_r));
            OP_SRA:   r.val = (sj < 0) ? ~((~i.vj) >> sh_r) : (i.vj >> sh_r);
            OP_OR:    r.val = i.vj | i.vk;
            OP_AND:   r.val = i.vj & i.vk;
            default:  ;
        endcase
        return r;
    endfunction

    // Behavioural timing model: a queue of in-flight instructions (at most
    // one awaiting compute) and the currently broadcast result.
    ins_t     m_q[$];
    bit       m_flag = 1'b0;
    ins_t     m_out_ins;
    alu_res_t m_out;

    always @(posedge clk) begin
        ins_t nxt;
        if (rst || roll) begin
            m_q.delete();
            m_flag = 1'b0;
        end else if (rdy) begin
            m_flag = (m_q.size() != 0);
            if (m_flag) begin
                m_out_ins = m_q.pop_front();
                m_out     = ref_exec(m_out_ins);
            end
            if (in_valid) begin
                nxt = '{op: in_op, vj: in_vj, vk: in_vk, imm: in_imm, pc: in_pc, rob: in_rob_idx};
                m_q.push_back(nxt);
            end
        end
    end

    // Every-cycle comparison of the broadcast against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("flag", {31'd0, alu_flag}, {31'd0, m_flag});
            if (m_flag) begin
                chk("rob_idx", {28'd0, alu_rob_idx}, {28'd0, m_out_ins.rob});
                chk("val", alu_val, m_out.val);
                chk("jump", {31'd0, alu_jump}, {31'd0, m_out.jump});
                chk("target", alu_target, m_out.target);
            end
        end
    end

    // Present one instruction for exactly one edge; call #1 after an edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
        in_op = op; in_vj = vj; in_vk = vk; in_imm = imm; in_pc = pc; in_rob_idx = rob;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; rdy = 1'b1; roll = 1'b0; in_valid = 1'b0;
        in_op = '0; in_vj = '0; in_vk = '0; in_imm = '0; in_pc = '0; in_rob_idx = '0;
        tick(2);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state.
        chk("rst_flag", {31'd0, alu_flag}, 32'd0);
        chk("rst_rob", {28'd0, alu_rob_idx}, 32'd0);
        chk("rst_val", alu_val, 32'd0);
        chk("rst_jump", {31'd0, alu_jump}, 32'd0);
        chk("rst_target", alu_target, 32'd0);

        // ADDI wraps to zero; pulse one cycle after the edge following issue.
        issue(OP_ADDI, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h200, 4'd3);
        chk("addi_early_flag", {31'd0, alu_flag}, 32'd0);
        tick(1);
        chk("addi_flag", {31'd0, alu_flag}, 32'd1);
        chk("addi_rob", {28'd0, alu_rob_idx}, 32'd3);
        chk("addi_val", alu_val, 32'h0);
        tick(1);
        chk("addi_pulse_end", {31'd0, alu_flag}, 32'd0);

        // Back-to-back SRA then SRL.
        issue(OP_SRA, 32'h8000_0000, 32'h24, 32'd0, 32'h300, 4'd5);
        issue(OP_SRL, 32'h8000_0000, 32'h24, 32'd0, 32'h304, 4'd6);
        chk("sra_flag", {31'd0, alu_flag}, 32'd1);
        chk("sra_rob", {28'd0, alu_rob_idx}, 32'd5);
        chk("sra_val", alu_val, 32'hF800_0000);
        tick(1);
        chk("srl_flag", {31'd0, alu_flag}, 32'd1);
        chk("srl_rob", {28'd0, alu_rob_idx}, 32'd6);
        chk("srl_val", alu_val, 32'h0800_0000);

        // BLT taken (signed), BLTU not taken (unsigned).
        issue(OP_BLT, 32'hFFFF_FFFE, 32'd1, 32'h20, 32'h100, 4'd7);
        issue(OP_BLTU, 32'hFFFF_FFFE, 32'd1, 32'h20, 32'h100, 4'd8);
        chk("blt_jump", {31'd0, alu_jump}, 32'd1);
        chk("blt_target", alu_target, 32'h120);
        chk("blt_val", alu_val, 32'd0);
        tick(1);
        chk("bltu_jump", {31'd0, alu_jump}, 32'd0);
        chk("bltu_target", alu_target, 32'h104);

        // JALR clears bit 0 of the target.
        issue(OP_JALR, 32'h1001, 32'd0, 32'd2, 32'h40, 4'd9);
        tick(1);
        chk("jalr_val", alu_val, 32'h44);
        chk("jalr_target", alu_target, 32'h1002);
        chk("jalr_jump", {31'd0, alu_jump}, 32'd1);

        // Roll one edge after issue kills it; a later issue broadcasts.
        tick(1);
        issue(OP_ADD, 32'd10, 32'd20, 32'd0, 32'h500, 4'd2);
        roll = 1'b1;
        tick(1);
        roll = 1'b0;
        chk("roll_kill0", {31'd0, alu_flag}, 32'd0);
        issue(OP_ADD, 32'd10, 32'd20, 32'd0, 32'h500, 4'd4);
        chk("roll_kill1", {31'd0, alu_flag}, 32'd0);
        tick(1);
        chk("post_roll_flag", {31'd0, alu_flag}, 32'd1);
        chk("post_roll_rob", {28'd0, alu_rob_idx}, 32'd4);
        chk("post_roll_val", alu_val, 32'd30);

        // rdy low for 3 cycles with a result in E1 delays it by 3 cycles.
        tick(1);
        issue(OP_XORI, 32'h0F0F_0F0F, 32'd0, 32'hFFFF_FFFF, 32'h600, 4'd11);
        rdy = 1'b0;
        in_valid = 1'b1; in_op = OP_ADD; in_rob_idx = 4'd1;
        tick(3);
        in_valid = 1'b0;
        chk("frozen_flag", {31'd0, alu_flag}, 32'd0);
        rdy = 1'b1;
        tick(1);
        chk("thaw_flag", {31'd0, alu_flag}, 32'd1);
        chk("thaw_rob", {28'd0, alu_rob_idx}, 32'd11);
        chk("thaw_val", alu_val, 32'hF0F0_F0F0);
        tick(1);
        chk("thaw_pulse_end", {31'd0, alu_flag}, 32'd0);

        // A held pulse stays high while frozen; reset clears it regardless.
        issue(OP_LUI, 32'd0, 32'd0, 32'hABCD_E000, 32'h700, 4'd12);
        tick(1);
        rdy = 1'b0;
        tick(1);
        chk("held_flag", {31'd0, alu_flag}, 32'd1);
        chk("held_val", alu_val, 32'hABCD_E000);
        rst = 1'b1;
        tick(1);
        rst = 1'b0; rdy = 1'b1;
        chk("rst_frozen_flag", {31'd0, alu_flag}, 32'd0);
        tick(1);

        // Undefined opcode still completes with a null result.
        issue(6'd60, 32'h1234, 32'h5678, 32'h10, 32'h800, 4'd13);
        tick(1);
        chk("undef_flag", {31'd0, alu_flag}, 32'd1);
        chk("undef_val", alu_val, 32'd0);
        chk("undef_target", alu_target, 32'h804);

        // Randomized traffic, checked every cycle against the model.
        for (int n = 0; n < 2000; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_op      = 6'($urandom_range(0, 40));
            in_vj      = rand_val();
            in_vk      = ($urandom_range(0, 3) == 0) ? in_vj : rand_val();
            in_imm     = rand_val();
            in_pc      = $urandom & 32'hFFFF_FFFC;
            in_rob_idx = 4'($urandom);
            rdy        = ($urandom_range(0, 6) != 0);
            roll       = ($urandom_range(0, 40) == 0);
            rst        = ($urandom_range(0, 150) == 0);
            tick(1);
        end
        in_valid = 1'b0; roll = 1'b0; rst = 1'b0; rdy = 1'b1;
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Two-stage pipelined RV32I integer execute unit sitting between the reservation station and the common data bus. It accepts one issued instruction per cycle from the RS, computes the integer result and the control-flow outcome, and broadcasts a one-cycle result pulse. The RS and ROB snoop this pulse to wake dependents and mark entries complete. It is the consumer end of the RS issue interface and the producer of the ALU result broadcast.

## Interface
- ROB_W, 4, ROB index width (matches `ROB_INDEX_RANGE)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- roll  in  1  misprediction flush; synchronous, same effect as rst
- in_valid  in  1  issue strobe from the RS (its ALU_commit)
- in_op  in  6  internal opcode (shared opcode constants)
- in_vj, in_vk  in  32  source operand values
- in_rob_idx  in  ROB_W  destination ROB entry
- in_imm  in  32  sign-extended immediate
- in_pc  in  32  instruction PC
- alu_flag  out  1  result broadcast valid; single-cycle pulse
- alu_rob_idx  out  ROB_W  ROB entry of the broadcast result
- alu_val  out  32  result value
- alu_jump  out  1  control transfer taken (branch taken, JAL or JALR)
- alu_target  out  32  resolved next PC; PC+4 when not taken

## Operation
- Stage E1: registers the inputs when in_valid=1 and rdy=1. Sets v1.
- Stage E2: combinational compute from the E1 registers. Result registers load at the next edge. alu_flag = v1 delayed by one cycle.
- Results by opcode (all arithmetic mod 2^32):
  - LUI: imm.
  - AUIPC: pc+imm.
  - JAL: val = pc+4, target = pc+imm, jump = 1.
  - JALR: val = pc+4, target = (vj+imm) & ~1, jump = 1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: compare vj with vk, signed or unsigned as named. val = 0, jump = condition, target = pc+imm if taken, else pc+4.
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI: vj op imm. SLT* results are 0 or 1.
  - SLLI/SRLI/SRAI: shift amount is imm[4:0]. SRA/SRAI are arithmetic.
  - ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND: vj op vk. Shift amount is vk[4:0].
- Any other opcode (loads, stores, undefined): broadcast val = 0, jump = 0, target = pc+4. The ROB entry must still complete.
- Non-jump, non-branch ops: jump = 0, target = pc+4.
- Throughput: one instruction per cycle. There is no backpressure; the RS issues at most one instruction per cycle.

## Timing
- Latency: in_valid sampled at edge t (E1 load); alu_flag and all result outputs are high/valid during the cycle after edge t+1.
- Reset/roll: at the edge where rst or roll is high, v1 and alu_flag clear to 0. alu_rob_idx, alu_val and alu_target reset to 0, alu_jump to 0. An in_valid present in the same cycle is dropped.
- roll kills both stages. Nothing issued before the roll edge may broadcast after it.
- rdy=0: no register changes, including alu_flag. A held pulse stays high for the frozen cycles, and the consumers are also frozen. in_valid is ignored.
- rst or roll takes priority over rdy=0.
- Back-to-back issue produces back-to-back alu_flag pulses with the correct per-instruction rob_idx.
- alu_flag is 0 in any cycle with no result. Other outputs hold their last values and are don't-care when alu_flag=0.

## Structure
- Opcode constants (6-bit) and ROB width macros live in the shared define package; no local opcode literals.
- One natural sub-module: alu_exec_core, the purely combinational E2 datapath computing {val, jump, target} from op, vj, vk, imm, pc. The top holds the pipeline registers, valid bits and flush logic.

## Test plan
- ADDI vj=0xFFFFFFFF, imm=1, rob=3 issued at edge t -> alu_flag pulse one cycle after edge t+1, rob_idx=3, val=0x0.
- SRA vj=0x80000000, vk=0x24; then SRL with the same operands back-to-back -> consecutive pulses, val=0xF8000000 then 0x08000000.
- BLT vj=0xFFFFFFFE, vk=1, pc=0x100, imm=0x20 -> jump=1, target=0x120, val=0. BLTU with the same values -> jump=0, target=0x104.
- JALR vj=0x1001, imm=2, pc=0x40 -> val=0x44, target=0x1002, jump=1.
- Issue at edge t, roll at edge t+1 -> no alu_flag ever. An instruction issued at edge t+2 broadcasts normally.
- rdy low for 3 cycles while a result is in E1 -> broadcast is delayed exactly 3 cycles with unchanged values. Reset during that period clears alu_flag at the reset edge.
